// File: rtl/rbm_hidden_sched.sv
// Hidden-unit sequencer: walks j = 0..h_count-1, fetching column j, running the
// GEMV+sigmoid core, optionally Bernoulli-sampling, and writing the hidden buffer.
module rbm_hidden_sched #(
    parameter int I_DIM = 256,
    parameter int H_DIM = 64,
    localparam int HW = $clog2(H_DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [HW:0]   h_count,
    input  logic          sample_en,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          col_req,
    output logic [HW-1:0] col_idx,
    input  logic          col_ready,
    output logic          core_start,
    input  logic          core_busy,
    input  logic [15:0]   core_p,
    input  logic [15:0]   rnd,
    output logic          h_we,
    output logic [HW-1:0] h_addr,
    output logic [15:0]   h_p,
    output logic          h_s
);

    if (H_DIM < 2 || I_DIM < 1) begin : g_bad_params
        $error("rbm_hidden_sched: H_DIM must be >= 2 and I_DIM >= 1");
    end

    typedef enum logic [2:0] {IDLE, REQ, LAUNCH, WAITB, RUN, WRITE, DRAIN} state_t;

    state_t        state;
    logic [HW-1:0] j;
    logic [HW:0]   h_cnt_q;
    logic          samp_q;
    logic          core_busy_q;

    logic start_ok;
    logic last_unit;
    logic s_next;

    assign start_ok  = (h_count != '0) && (h_count <= (HW+1)'(H_DIM));
    assign last_unit = ({1'b0, j} == (h_cnt_q - 1'b1));
    assign s_next    = samp_q && (rnd < core_p);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            j           <= '0;
            h_cnt_q     <= '0;
            samp_q      <= 1'b0;
            core_busy_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            col_req     <= 1'b0;
            col_idx     <= '0;
            core_start  <= 1'b0;
            h_we        <= 1'b0;
            h_addr      <= '0;
            h_p         <= '0;
            h_s         <= 1'b0;
        end else begin
            core_busy_q <= core_busy;
            err         <= 1'b0;
            done        <= 1'b0;
            core_start  <= 1'b0;
            h_we        <= 1'b0;

            // Abort preempts every active state; DRAIN itself just keeps draining.
            if (abort && state != IDLE && state != DRAIN) begin
                col_req <= 1'b0;
                state   <= DRAIN;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (start_ok) begin
                                h_cnt_q <= h_count;
                                samp_q  <= sample_en;
                                j       <= '0;
                                col_idx <= '0;
                                col_req <= 1'b1;
                                busy    <= 1'b1;
                                state   <= REQ;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    REQ: begin
                        if (col_ready) begin
                            core_start <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end
                    LAUNCH: state <= WAITB;
                    WAITB: begin
                        if (core_busy) begin
                            col_req <= 1'b0;
                            state   <= RUN;
                        end
                    end
                    RUN: begin
                        if (core_busy_q && !core_busy) begin
                            h_we   <= 1'b1;
                            h_addr <= j;
                            h_p    <= core_p;
                            h_s    <= s_next;
                            done   <= last_unit;
                            state  <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (last_unit) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            j       <= j + 1'b1;
                            col_idx <= j + 1'b1;
                            col_req <= 1'b1;
                            state   <= REQ;
                        end
                    end
                    DRAIN: begin
                        if (!core_busy) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rbm_hidden_sched.sv
// Directed bench for rbm_hidden_sched with a behavioural core / column-memory model.
module tb_rbm_hidden_sched;
    localparam int H_DIM = 64;
    localparam int HW    = 6;

    logic          clk = 1'b0;
    logic          rst, start, abort, sample_en;
    logic [HW:0]   h_count;
    logic          busy, done, err, col_req, core_start, h_we, h_s;
    logic [HW-1:0] col_idx, h_addr;
    logic          col_ready = 1'b0;
    logic          core_busy;
    logic [15:0]   core_p, rnd, h_p;

    rbm_hidden_sched #(.I_DIM(256), .H_DIM(H_DIM)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .h_count(h_count),
        .sample_en(sample_en), .busy(busy), .done(done), .err(err),
        .col_req(col_req), .col_idx(col_idx), .col_ready(col_ready),
        .core_start(core_start), .core_busy(core_busy), .core_p(core_p), .rnd(rnd),
        .h_we(h_we), .h_addr(h_addr), .h_p(h_p), .h_s(h_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HW-1:0] addr;
        logic [15:0]   p;
        logic [15:0]   rnd;
        logic          s;
    } vec_t;
    vec_t vt [0:11];

    typedef struct {
        logic [HW-1:0] addr;
        logic [15:0]   p;
        logic          s;
        logic          d;
    } wr_t;
    wr_t wq [$];

    logic [15:0] p_tab   [0:H_DIM-1];
    logic [15:0] rnd_tab [0:H_DIM-1];
    int          busy_len[0:H_DIM-1];
    int          rdy_dly [0:H_DIM-1];
    bit          ready_tied = 1'b1;

    int n_chk = 0, n_fail = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, cyc = 0;
    int idx_jumps = 0, cr_cnt = 0;
    int req1_cyc = 0, rdy1_cyc = 0, cs1_cyc = 0;
    logic cr_prev = 1'b0, rdy_prev = 1'b0;
    logic [HW-1:0] idx_prev = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor plus column-memory model (col_ready after rdy_dly cycles of col_req)
    always @(negedge clk) begin
        cyc++;
        if (h_we) wq.push_back('{h_addr, h_p, h_s, done});
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (core_start && col_idx == 1) cs1_cyc = cyc;
        if (col_req && cr_prev && col_idx != idx_prev) idx_jumps++;
        if (col_req && !cr_prev && col_idx == 1) req1_cyc = cyc;
        if (ready_tied) col_ready = 1'b1;
        else if (!col_req) begin
            cr_cnt = 0;
            col_ready = 1'b0;
        end else begin
            col_ready = (cr_cnt >= rdy_dly[col_idx]);
            cr_cnt++;
        end
        if (!ready_tied && col_ready && !rdy_prev && col_idx == 1) rdy1_cyc = cyc;
        rdy_prev = col_ready;
        cr_prev  = col_req;
        idx_prev = col_idx;
    end

    // Core model: busy one cycle after launch for busy_len cycles; result valid as busy drops
    initial begin
        logic [HW-1:0] idx;
        core_busy = 1'b0;
        core_p    = 16'h0000;
        rnd       = 16'h0000;
        forever begin
            @(posedge clk);
            if (core_start && !rst) begin
                idx = col_idx;
                #1 core_busy = 1'b1;
                core_p = 16'hDEAD;
                rnd    = 16'h0000;
                repeat (busy_len[idx]) @(posedge clk);
                #1 core_p = p_tab[idx];
                rnd       = rnd_tab[idx];
                core_busy = 1'b0;
                @(posedge clk);
                #1 core_p = ~p_tab[idx];
                rnd       = ~rnd_tab[idx];
            end
        end
    end

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            p_tab[vt[base+i].addr]   = vt[base+i].p;
            rnd_tab[vt[base+i].addr] = vt[base+i].rnd;
        end
    endtask

    task automatic pulse_start(input logic [HW:0] hc, input logic se);
        @(posedge clk);
        #1 start = 1'b1;
        h_count   = hc;
        sample_en = se;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({tag, ".done_seen"}, (k < 3000), 1);
        @(negedge clk);
        chk({tag, ".busy_after_done"}, busy, 0);
    endtask

    task automatic wait_writes(input string tag, input int n);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (wq.size() >= n) break;
        end
        chk({tag, ".writes_seen"}, (k < 2000), 1);
    endtask

    task automatic check_frame(input string tag, input int base, input int n);
        chk({tag, ".nwr"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk($sformatf("%s.addr%0d", tag, i), wq[i].addr, vt[base+i].addr);
            chk($sformatf("%s.p%0d", tag, i), wq[i].p, vt[base+i].p);
            chk($sformatf("%s.s%0d", tag, i), wq[i].s, vt[base+i].s);
            chk($sformatf("%s.done_on_wr%0d", tag, i), wq[i].d, (i == n - 1));
        end
        chk({tag, ".done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        int k;
        int drain_cyc, bad, nw, dc;

        vt[0]  = '{6'd0, 16'h1000, 16'h0000, 1'b0};
        vt[1]  = '{6'd1, 16'h2000, 16'h0000, 1'b0};
        vt[2]  = '{6'd2, 16'h3000, 16'h0000, 1'b0};
        vt[3]  = '{6'd3, 16'h4000, 16'h0000, 1'b0};
        vt[4]  = '{6'd0, 16'h8000, 16'h7FFF, 1'b1};
        vt[5]  = '{6'd1, 16'h8000, 16'h8000, 1'b0};
        vt[6]  = '{6'd2, 16'h0000, 16'h0000, 1'b0};
        vt[7]  = '{6'd3, 16'hFFFF, 16'hFFFE, 1'b1};
        vt[8]  = '{6'd4, 16'hFFFF, 16'hFFFF, 1'b0};
        vt[9]  = '{6'd0, 16'h00FF, 16'h0100, 1'b0};
        vt[10] = '{6'd1, 16'h0101, 16'h0100, 1'b1};
        vt[11] = '{6'd2, 16'hABCD, 16'h1234, 1'b1};

        for (int i = 0; i < H_DIM; i++) begin
            p_tab[i]    = 16'h5555;
            rnd_tab[i]  = 16'h0000;
            busy_len[i] = 3;
            rdy_dly[i]  = 0;
        end

        rst = 1'b1; start = 1'b0; abort = 1'b0; h_count = '0; sample_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, err, col_req, col_idx, core_start, h_we, h_addr, h_p, h_s}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Frame A: no sampling, rnd=0 so a wrongly enabled sampler would set h_s
        load(0, 4); wq.delete(); done_cnt = 0;
        pulse_start(7'd4, 1'b0);
        wait_done("A");
        check_frame("A", 0, 4);

        // Frame B: sampling thresholds
        load(4, 5); wq.delete(); done_cnt = 0;
        pulse_start(7'd5, 1'b1);
        wait_done("B");
        check_frame("B", 4, 5);

        // Frame C: column 1 arrives 5 cycles late
        load(9, 3); wq.delete(); done_cnt = 0; idx_jumps = 0;
        rdy_dly[1] = 5; ready_tied = 1'b0;
        req1_cyc = -100; rdy1_cyc = -100; cs1_cyc = -100;
        pulse_start(7'd3, 1'b1);
        wait_done("C");
        check_frame("C", 9, 3);
        chk("C.req_to_ready", rdy1_cyc - req1_cyc, 5);
        chk("C.ready_to_core_start", cs1_cyc - rdy1_cyc, 1);
        chk("C.col_idx_stable", idx_jumps, 0);
        ready_tied = 1'b1; rdy_dly[1] = 0;

        // Frame D: full H_DIM sweep
        for (int i = 0; i < H_DIM; i++) begin
            p_tab[i] = 16'(i * 16'h0101);
            busy_len[i] = 1;
        end
        wq.delete(); done_cnt = 0;
        pulse_start(7'd64, 1'b0);
        wait_done("D");
        chk("D.nwr", wq.size(), 64);
        if (wq.size() == 64) begin
            chk("D.first_addr", wq[0].addr, 0);
            chk("D.last_addr", wq[63].addr, 63);
            chk("D.last_p", wq[63].p, 16'h3F3F);
            chk("D.last_done", wq[63].d, 1);
        end
        chk("D.done_cnt", done_cnt, 1);
        for (int i = 0; i < H_DIM; i++) busy_len[i] = 3;

        // Rejected starts
        for (int t = 0; t < 2; t++) begin
            err_cnt = 0;
            pulse_start((t == 0) ? 7'd0 : 7'd65, 1'b0);
            @(negedge clk);
            chk($sformatf("err%0d.err", t), err, 1);
            chk($sformatf("err%0d.busy", t), busy, 0);
            chk($sformatf("err%0d.col_req", t), col_req, 0);
            @(negedge clk);
            chk($sformatf("err%0d.err_one_cycle", t), {err, busy, col_req}, 0);
            chk($sformatf("err%0d.err_cnt", t), err_cnt, 1);
        end

        // Start while busy is ignored
        load(0, 4); wq.delete(); done_cnt = 0; err_cnt = 0;
        pulse_start(7'd4, 1'b0);
        wait_writes("M", 1);
        pulse_start(7'd2, 1'b1);
        wait_done("M");
        check_frame("M", 0, 4);
        chk("M.no_err", err_cnt, 0);

        // Abort during RUN of j=2, long core run
        busy_len[2] = 12; wq.delete(); done_cnt = 0;
        pulse_start(7'd4, 1'b0);
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (busy && core_busy && !col_req && col_idx == 2) break;
        end
        chk("AB.run2_seen", (k < 500), 1);
        nw = wq.size(); dc = done_cnt;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        drain_cyc = 0; bad = 0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!core_busy) break;
            if (!busy || col_req || core_start || h_we || done) bad++;
            drain_cyc++;
        end
        chk("AB.drain_cycles", drain_cyc, 9);
        chk("AB.drain_outputs", bad, 0);
        chk("AB.busy_last_drain", busy, 1);
        @(negedge clk);
        chk("AB.idle_after_drain", busy, 0);
        chk("AB.no_more_writes", wq.size(), nw);
        chk("AB.no_done", done_cnt, dc);
        busy_len[2] = 3;

        // Abort alone in IDLE does nothing; abort with start lets start win
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("AI.idle_abort", {busy, err, col_req}, 0);
        wq.delete(); done_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1; abort = 1'b1; h_count = 7'd4; sample_en = 1'b0;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("AS.started", {busy, col_req, col_idx}, {1'b1, 1'b1, 6'd0});
        wait_done("AS");
        check_frame("AS", 0, 4);

        // Reset mid-sweep
        wq.delete();
        pulse_start(7'd4, 1'b0);
        wait_writes("R", 2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("R.outputs_zero", {busy, done, err, col_req, col_idx, core_start, h_we, h_addr, h_p, h_s}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("R.stays_idle", {busy, col_req, h_we}, 0);
        chk("never_done_and_err", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rbm_hidden_sched.md
Name: rbm_hidden_sched

Overview:
Sequencer that drives the single-hidden-unit GEMV+sigmoid core across all hidden units of one frame. For each hidden index j it:
- requests weight column j and bias j from the memory wrapper;
- launches the core and captures its probability output;
- optionally draws a Bernoulli sample against an external LFSR value;
- writes both the probability and the sample into the hidden buffer.

It sits between the AXI-Lite register shell (start/h_count/sample_en) and the core plus weight/bias BRAM wrapper. It feeds the positive and negative phases of the outer-product accumulator.

Parameters:
I_DIM, 256, visible length per GEMV; only informational here; passed to core.
H_DIM, 64, maximum hidden units per frame; sets width of index ports.
HW, $clog2(H_DIM), index width (derived localparam, not overridable).

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
start  in  1  one-cycle pulse; begins a frame sweep; ignored unless state IDLE
abort  in  1  level/pulse; terminates sweep at next edge
h_count  in  HW+1  number of hidden units to process, valid range 1..H_DIM; sampled on accepted start
sample_en  in  1  1 = produce Bernoulli samples; sampled on accepted start
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse at normal completion
err  out  1  one-cycle pulse when start rejected for bad h_count
col_req  out  1  request weight column / bias for col_idx
col_idx  out  HW  hidden index requested
col_ready  in  1  wrapper: w_col and b_j for col_idx stable at core inputs
core_start  out  1  one-cycle launch pulse to core
core_busy  in  1  core busy
core_p  in  16  core probability, Q0.16
rnd  in  16  LFSR output, free-running
h_we  out  1  hidden buffer write strobe
h_addr  out  HW  hidden buffer address
h_p  out  16  probability written, Q0.16
h_s  out  1  sample bit written

Behaviour:
- Reset values: all outputs 0. State IDLE, j=0.
- States: IDLE, REQ, LAUNCH, WAITB, RUN, WRITE, DRAIN.
- IDLE, on start:
  - If h_count==0 or h_count>H_DIM: pulse err, stay IDLE, busy stays 0.
  - Otherwise latch h_count and sample_en, j<=0, go to REQ.
- REQ: col_req=1 and col_idx=j, held. On col_ready=1, go to LAUNCH. No timeout; waits indefinitely.
- LAUNCH: core_start=1 for exactly this cycle; col_req stays 1 until leaving WAITB. Go to WAITB.
- WAITB: wait for core_busy=1, then go to RUN. core_start must not re-pulse.
- RUN: on core_busy 1->0 (registered previous value 1, current 0), capture core_p in that cycle and go to WRITE.
  - Capture p = core_p.
  - s = sample_en ? (rnd < p, unsigned 16-bit) : 0. rnd is taken the same cycle.
- WRITE: h_we=1 for one cycle, with h_addr=j, h_p=p, h_s=s.
  - If j==h_count-1: done pulses this same cycle, then IDLE.
  - Otherwise j<=j+1, go to REQ.
- Latency per unit: ≥ col_ready wait + 1 (LAUNCH) + core latency (I_DIM+2) + 1 (WRITE). No overlap between units.
- busy=1 in every state except IDLE.
- Boundaries:
  - p=0 gives s=0 always. p=0xFFFF gives s=1 except when rnd=0xFFFF.
  - j never wraps. h_count=H_DIM ends at j=H_DIM-1.
  - start while busy is ignored: no err, no restart.
- abort (any non-IDLE state):
  - next state DRAIN; h_we, done, core_start and col_req forced 0 from that edge.
  - DRAIN holds until core_busy=0, then IDLE; busy stays 1 through DRAIN.
  - abort in IDLE: no effect.
  - abort and start in the same IDLE cycle: start wins.
- err and done never assert in the same cycle.
- rst mid-sweep: immediate IDLE, outputs zeroed. Buffer contents are not cleared by this block.

Test Plan:
- h_count=4, sample_en=0, col_ready tied 1, core model returns p=0x1000*(j+1) -> four h_we pulses, addr 0..3, h_p=0x1000,0x2000,0x3000,0x4000, h_s=0; done once, on the 4th write cycle; busy falls the next cycle.
- sample_en=1, p=0x8000, rnd forced 0x7FFF then 0x8000 at capture -> h_s=1 then 0; p=0 with rnd=0 -> h_s=0.
- col_ready delayed 5 cycles for j=1 -> core_start occurs exactly 1 cycle after col_ready rises; col_idx=1 held stable throughout.
- start with h_count=0 and with h_count=65 (H_DIM=64) -> err pulse, busy=0, no col_req.
- abort asserted during RUN of j=2 with core_busy high 10 more cycles -> no further h_we, no done; busy stays 1 for those 10 cycles, then IDLE; a new start then runs from j=0.
- start pulsed again mid-sweep and rst asserted mid-sweep -> second start ignored; rst gives all outputs 0 next cycle and state IDLE.
